gbuff_result_checker: RTL and testbench

//  Parametrised, synthesizable result checker for the TPU output global buffer.
//  - Waits for the TPU done pulse, then scans GBUFF_OUT against a golden memory, row by row.
//  - Compares every byte lane and counts mismatches.
//  - A watchdog forces the scan on timeout.
//  - Generalises the fixed 4x8-bit, byte-reversed bench check to any lane count, width and ordering.

---
 rtl/gbuff_result_checker.sv | 250 +++++++++++++++++++++++++
 tb/tb_gbuff_result_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuff_result_checker.sv
// ---------------------------------------------------------------------------
// gbuff_result_checker
//
// Checks the TPU output global buffer (GBUFF_OUT) against a golden memory.
// After the TPU done indication (or a watchdog timeout) it reads both
// memories row by row, compares every lane, and counts mismatching lanes.
//
// Lane pairing: result lane j is compared with golden lane LANES-1-j when
// LANE_REVERSE is 1, and with golden lane j when LANE_REVERSE is 0.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               1-cycle arm pulse; only accepted when idle
//   rows, tmo_lim       rows to check / watchdog limit (0 = off), sampled on start
//   tpu_done            TPU done indication, only looked at while waiting
//   gb_addr, gb_rdata   GBUFF_OUT read port (1-cycle read latency)
//   gd_addr, gd_rdata   golden read port (1-cycle read latency), same address
//   busy                high from the cycle after start up to the verdict cycle
//   chk_done            1-cycle pulse, verdict valid
//   pass                err_cnt==0 && !timeout, held until the next start
//   err_cnt             mismatching lane count, saturates at all-ones
//   timeout             watchdog fired before tpu_done
//
// Optional error log, enabled by defining GBUFF_CHK_ERRLOG_EN:
//   first_addr, first_lane, first_act, first_exp, first_vld
//   describe the lowest-address, lowest-lane mismatch of the run.
// ---------------------------------------------------------------------------
module gbuff_result_checker #(
    parameter int DATA_W       = 32,
    parameter int LANE_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int CNT_W        = 16,
    parameter int TMO_W        = 20,
    parameter int LANE_REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rows,
    input  logic [TMO_W-1:0]  tmo_lim,
    input  logic              tpu_done,
    output logic [ADDR_W-1:0] gb_addr,
    input  logic [DATA_W-1:0] gb_rdata,
    output logic [ADDR_W-1:0] gd_addr,
    input  logic [DATA_W-1:0] gd_rdata,
    output logic              busy,
    output logic              chk_done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              timeout
`ifdef GBUFF_CHK_ERRLOG_EN
    ,
    output logic [ADDR_W-1:0] first_addr,
    output logic [((DATA_W/LANE_W) > 1 ? $clog2(DATA_W/LANE_W) : 1)-1:0] first_lane,
    output logic [LANE_W-1:0] first_act,
    output logic [LANE_W-1:0] first_exp,
    output logic              first_vld
`endif
);

    localparam int LANES   = DATA_W / LANE_W;
    localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MW      = $clog2(LANES + 1);   // width of a per-row mismatch count
    localparam int SW      = CNT_W + MW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] rows_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic [TMO_W-1:0]  wdog_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              cmp_vld_reg;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic              timeout_reg;
    logic              verdict_reg;

    // ---------------- lane compare ----------------
    logic [LANES-1:0]  lane_mis;
    logic [LANE_W-1:0] act_lane [LANES];
    logic [LANE_W-1:0] exp_lane [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int K = (LANE_REVERSE != 0) ? (LANES - 1 - gi) : gi;
            assign act_lane[gi] = gb_rdata[gi*LANE_W +: LANE_W];
            assign exp_lane[gi] = gd_rdata[K*LANE_W +: LANE_W];
            assign lane_mis[gi] = (act_lane[gi] != exp_lane[gi]);
        end
    endgenerate

    logic [MW-1:0] mis_cnt;
    always_comb begin
        mis_cnt = '0;
        for (int j = 0; j < LANES; j++) begin
            mis_cnt = mis_cnt + MW'(lane_mis[j]);
        end
    end

    // Add in a wider field so the saturation test sees the true sum.
    logic [SW-1:0]    err_sum;
    logic [CNT_W-1:0] err_sat;
    always_comb begin
        err_sum = {{MW{1'b0}}, err_cnt_reg} + {{CNT_W{1'b0}}, mis_cnt};
        err_sat = (err_sum > {{MW{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    // Watchdog disabled when the latched limit is zero.
    logic wdog_hit;
    assign wdog_hit = (tmo_reg != '0) && (wdog_reg == tmo_reg - TMO_W'(1));

    // State after leaving WAIT; with no rows there is nothing to read.
    logic [2:0] scan_state;
    assign scan_state = (rows_reg == '0) ? S_REPORT : S_SCAN;

`ifdef GBUFF_CHK_ERRLOG_EN
    logic [ADDR_W-1:0]  cmp_addr_reg;
    logic [ADDR_W-1:0]  first_addr_reg;
    logic [LANE_IW-1:0] first_lane_reg;
    logic [LANE_W-1:0]  first_act_reg;
    logic [LANE_W-1:0]  first_exp_reg;
    logic               first_vld_reg;

    // Lowest mismatching lane of the current row (scan downwards so the
    // lowest index is the last one written).
    logic [LANE_IW-1:0] mis_lane;
    logic [LANE_W-1:0]  mis_act;
    logic [LANE_W-1:0]  mis_exp;
    always_comb begin
        mis_lane = '0;
        mis_act  = '0;
        mis_exp  = '0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (lane_mis[j]) begin
                mis_lane = LANE_IW'(j);
                mis_act  = act_lane[j];
                mis_exp  = exp_lane[j];
            end
        end
    end
`endif

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            rows_reg    <= '0;
            tmo_reg     <= '0;
            wdog_reg    <= '0;
            addr_reg    <= '0;
            cmp_vld_reg <= 1'b0;
            err_cnt_reg <= '0;
            timeout_reg <= 1'b0;
            verdict_reg <= 1'b0;
`ifdef GBUFF_CHK_ERRLOG_EN
            cmp_addr_reg   <= '0;
            first_addr_reg <= '0;
            first_lane_reg <= '0;
            first_act_reg  <= '0;
            first_exp_reg  <= '0;
            first_vld_reg  <= 1'b0;
`endif
        end else begin
            // Read data arrives one cycle after the address is issued.
            cmp_vld_reg <= (state_reg == S_SCAN);
            if (cmp_vld_reg) begin
                err_cnt_reg <= err_sat;
            end
`ifdef GBUFF_CHK_ERRLOG_EN
            cmp_addr_reg <= addr_reg;
            if (cmp_vld_reg && !first_vld_reg && (|lane_mis)) begin
                first_vld_reg  <= 1'b1;
                first_addr_reg <= cmp_addr_reg;
                first_lane_reg <= mis_lane;
                first_act_reg  <= mis_act;
                first_exp_reg  <= mis_exp;
            end
`endif
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_WAIT;
                        rows_reg    <= rows;
                        tmo_reg     <= tmo_lim;
                        wdog_reg    <= '0;
                        addr_reg    <= '0;
                        err_cnt_reg <= '0;
                        timeout_reg <= 1'b0;
                        verdict_reg <= 1'b0;
`ifdef GBUFF_CHK_ERRLOG_EN
                        first_addr_reg <= '0;
                        first_lane_reg <= '0;
                        first_act_reg  <= '0;
                        first_exp_reg  <= '0;
                        first_vld_reg  <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    wdog_reg <= wdog_reg + TMO_W'(1);
                    if (tpu_done) begin
                        state_reg <= scan_state;
                    end else if (wdog_hit) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= scan_state;
                    end
                end
                S_SCAN: begin
                    if (addr_reg == rows_reg - ADDR_W'(1)) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    state_reg <= S_REPORT;
                end
                S_REPORT: begin
                    verdict_reg <= 1'b1;
                    state_reg   <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign gb_addr  = addr_reg;
    assign gd_addr  = addr_reg;
    assign busy     = (state_reg != S_IDLE);
    assign chk_done = (state_reg == S_REPORT);
    assign err_cnt  = err_cnt_reg;
    assign timeout  = timeout_reg;
    // Counters are final in the REPORT cycle, so the verdict is valid with chk_done.
    assign pass     = (chk_done || verdict_reg) && (err_cnt_reg == '0) && !timeout_reg;

`ifdef GBUFF_CHK_ERRLOG_EN
    assign first_addr = first_addr_reg;
    assign first_lane = first_lane_reg;
    assign first_act  = first_act_reg;
    assign first_exp  = first_exp_reg;
    assign first_vld  = first_vld_reg;
`endif

endmodule

// File: tb/tb_gbuff_result_checker.sv
module tb_gbuff_result_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT 0: defaults (byte reverse, 16-bit counter) ----------------
    logic        start0, tpu0, busy0, done0, pass0, tmo_o0;
    logic [7:0]  rows0, gb_addr0, gd_addr0;
    logic [19:0] tmo0;
    logic [31:0] gb_rdata0, gd_rdata0;
    logic [15:0] err0;
    logic [31:0] res0 [256];
    logic [31:0] gold0 [256];

    // ---------------- DUT 1: straight mapping, 2-bit counter ----------------
    logic        start1, tpu1, busy1, done1, pass1, tmo_o1;
    logic [7:0]  rows1, gb_addr1, gd_addr1;
    logic [19:0] tmo1;
    logic [31:0] gb_rdata1, gd_rdata1;
    logic [1:0]  err1;
    logic [31:0] res1 [256];
    logic [31:0] gold1 [256];

`ifdef GBUFF_CHK_ERRLOG_EN
    logic [7:0] fa0, fact0, fexp0, fa1, fact1, fexp1;
    logic [1:0] fl0, fl1;
    logic       fv0, fv1;
`endif

    gbuff_result_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .rows(rows0), .tmo_lim(tmo0),
        .tpu_done(tpu0), .gb_addr(gb_addr0), .gb_rdata(gb_rdata0),
        .gd_addr(gd_addr0), .gd_rdata(gd_rdata0), .busy(busy0),
        .chk_done(done0), .pass(pass0), .err_cnt(err0), .timeout(tmo_o0)
`ifdef GBUFF_CHK_ERRLOG_EN
        , .first_addr(fa0), .first_lane(fl0), .first_act(fact0),
        .first_exp(fexp0), .first_vld(fv0)
`endif
    );

    gbuff_result_checker #(.CNT_W(2), .LANE_REVERSE(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .rows(rows1), .tmo_lim(tmo1),
        .tpu_done(tpu1), .gb_addr(gb_addr1), .gb_rdata(gb_rdata1),
        .gd_addr(gd_addr1), .gd_rdata(gd_rdata1), .busy(busy1),
        .chk_done(done1), .pass(pass1), .err_cnt(err1), .timeout(tmo_o1)
`ifdef GBUFF_CHK_ERRLOG_EN
        , .first_addr(fa1), .first_lane(fl1), .first_act(fact1),
        .first_exp(fexp1), .first_vld(fv1)
`endif
    );

    // Memory models with 1-cycle read latency.
    always @(posedge clk) begin
        gb_rdata0 <= res0[gb_addr0];
        gd_rdata0 <= gold0[gd_addr0];
        gb_rdata1 <= res1[gb_addr1];
        gd_rdata1 <= gold1[gd_addr1];
    end

    typedef struct {
        int unsigned done_cyc;
        logic        pass;
        logic [15:0] err;
        logic        tmo;
        logic        fvld;
        logic [7:0]  faddr;
        logic [1:0]  flane;
        logic [7:0]  fact;
        logic [7:0]  fexp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic exp_t mk(input logic p, input logic [15:0] e, input logic t,
                                input logic fv, input logic [7:0] fa, input logic [1:0] fl,
                                input logic [7:0] fac, input logic [7:0] fex);
        exp_t r;
        r.done_cyc = 0; r.pass = p; r.err = e; r.tmo = t;
        r.fvld = fv; r.faddr = fa; r.flane = fl; r.fact = fac; r.fexp = fex;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin
                chk("u0_spurious_done", {31'd0, done0}, 32'd0);
            end else begin
                e = q0.pop_front();
                $display("[TB] u0 verdict cyc=%0d pass=%0b err_cnt=%0d timeout=%0b",
                         cyc, pass0, err0, tmo_o0);
                chk("u0_done_cycle", cyc, e.done_cyc);
                chk("u0_pass", {31'd0, pass0}, {31'd0, e.pass});
                chk("u0_err_cnt", {16'd0, err0}, {16'd0, e.err});
                chk("u0_timeout", {31'd0, tmo_o0}, {31'd0, e.tmo});
`ifdef GBUFF_CHK_ERRLOG_EN
                chk("u0_first_vld", {31'd0, fv0}, {31'd0, e.fvld});
                chk("u0_first_addr", {24'd0, fa0}, {24'd0, e.faddr});
                chk("u0_first_lane", {30'd0, fl0}, {30'd0, e.flane});
                chk("u0_first_act", {24'd0, fact0}, {24'd0, e.fact});
                chk("u0_first_exp", {24'd0, fexp0}, {24'd0, e.fexp});
`endif
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("u1_spurious_done", {31'd0, done1}, 32'd0);
            end else begin
                e = q1.pop_front();
                $display("[TB] u1 verdict cyc=%0d pass=%0b err_cnt=%0d timeout=%0b",
                         cyc, pass1, err1, tmo_o1);
                chk("u1_done_cycle", cyc, e.done_cyc);
                chk("u1_pass", {31'd0, pass1}, {31'd0, e.pass});
                chk("u1_err_cnt", {30'd0, err1}, {16'd0, e.err});
                chk("u1_timeout", {31'd0, tmo_o1}, {31'd0, e.tmo});
            end
        end
    end

    // ---------------- stimulus ----------------
    // dly < 0: tpu_done never rises (watchdog run).
    task automatic run(input int inst, input logic [7:0] rows, input logic [19:0] tmo,
                       input int dly, input logic mid_start, input exp_t e);
        int unsigned s;
        @(posedge clk); #1;
        s = cyc;
        if (inst == 0) begin start0 = 1'b1; rows0 = rows; tmo0 = tmo; end
        else           begin start1 = 1'b1; rows1 = rows; tmo1 = tmo; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk("busy_after_start", {31'd0, (inst == 0) ? busy0 : busy1}, 32'd1);
        if (dly >= 0) begin
            repeat (dly) @(posedge clk);
            #1;
            if (inst == 0) tpu0 = 1'b1; else tpu1 = 1'b1;
            e.done_cyc = (rows == 0) ? cyc + 1 : cyc + rows + 2;
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
            @(posedge clk); #1;
            tpu0 = 1'b0; tpu1 = 1'b0;
            if (mid_start) begin
                // Now in SCAN: this start must be ignored.
                if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
                @(posedge clk); #1;
                start0 = 1'b0; start1 = 1'b0;
            end
        end else begin
            e.done_cyc = s + tmo + 2 + rows;
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int i = 0; i < 1000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            chk("verdict_wait_expired", q0.size() + q1.size(), 32'd0);
            q0.delete(); q1.delete();
        end
    endtask

    task automatic fill_mem();
        logic [7:0] b;
        for (int r = 0; r < 256; r++) begin
            b = r[7:0];
            res0[r]  = {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
            gold0[r] = {8'h40 + b, 8'h30 + b, 8'h20 + b, 8'h10 + b};
            res1[r]  = {8'hA0 + b, 8'hB0 + b, 8'hC0 + b, 8'hD0 + b};
            gold1[r] = res1[r];
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 0; tpu0 = 0; rows0 = 0; tmo0 = 0;
        start1 = 0; tpu1 = 0; rows1 = 0; tmo1 = 0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_err", {16'd0, err0}, 32'd0);
        chk("rst_timeout", {31'd0, tmo_o0}, 32'd0);
        chk("rst_gb_addr", {24'd0, gb_addr0}, 32'd0);
        chk("rst_u1_pass", {31'd0, pass1}, 32'd0);

        // Matching data, byte reversed golden.
        run(0, 8'd4, 20'd0, 9, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        // rows == 0: verdict one cycle after tpu_done.
        run(0, 8'd0, 20'd0, 3, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        // start pulsed during SCAN is ignored.
        run(0, 8'd4, 20'd0, 2, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        // tpu_done in the same cycle the watchdog would fire wins (tmo_lim=3).
        run(0, 8'd4, 20'd3, 2, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0));

        // Lane mismatches: row 2 lane 0 (0x5A vs 0x3C), row 3 lanes 1 and 3.
        res0[2]  = 32'h1222325A;
        gold0[2] = 32'h3C322212;
        res0[3]  = 32'hEC23CC43;
        run(0, 8'd4, 20'd0, 4, 1'b0, mk(0, 16'd3, 0, 1, 8'd2, 2'd0, 8'h5A, 8'h3C));

        // Reset for 2 cycles in the middle of SCAN: no verdict, all outputs 0.
        @(posedge clk); #1 start0 = 1'b1; rows0 = 8'd8; tmo0 = 20'd0;
        @(posedge clk); #1 start0 = 1'b0; tpu0 = 1'b1;
        @(posedge clk); #1 tpu0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_done", {31'd0, done0}, 32'd0);
        chk("midrst_pass", {31'd0, pass0}, 32'd0);
        chk("midrst_err", {16'd0, err0}, 32'd0);
        chk("midrst_gb_addr", {24'd0, gb_addr0}, 32'd0);
`ifdef GBUFF_CHK_ERRLOG_EN
        chk("midrst_first_vld", {31'd0, fv0}, 32'd0);
`endif
        repeat (15) @(posedge clk);   // monitor flags any stray verdict here

        // Watchdog: tpu_done never rises, data matches, pass must still be 0.
        fill_mem();
        run(0, 8'd4, 20'd50, -1, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0));
        // Normal run afterwards clears timeout.
        run(0, 8'd3, 20'd50, 5, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0));

        // Straight mapping instance.
        run(1, 8'd4, 20'd0, 3, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        // 5 mismatching lanes into a 2-bit counter -> saturates at 3.
        res1[0] = ~gold1[0];
        res1[1] = gold1[1] ^ 32'h000000FF;
        run(1, 8'd2, 20'd0, 3, 1'b0, mk(0, 16'd3, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
